// File: rtl/mpmc12_pkg.sv
// Shared types and limits for the multiport memory controller read-ack generator.
package mpmc12_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } ack_state_t;

    localparam int unsigned MAX_NPORT   = 16;
    localparam int unsigned MAX_STRETCH = 16;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mpmc12_ack_chan.sv
// One ack channel: stretches each read event into a STRETCH-cycle ack followed by
// at least GAP low cycles, queueing back-to-back events in a saturating counter.
module mpmc12_ack_chan
    import mpmc12_pkg::*;
#(
    parameter int unsigned STRETCH = 4,
    parameter int unsigned GAP     = 2,
    parameter int unsigned PENDW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             evt,
    input  logic             ovf_clr,
    output logic             ack_stretch,
    output logic             ack_pulse,
    output logic [PENDW-1:0] pend_cnt,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned      CNTW       = $clog2(max_u(STRETCH, GAP)) + 1;
    localparam logic [CNTW-1:0]  STRETCH_LD = CNTW'(STRETCH - 1);
    localparam logic [CNTW-1:0]  GAP_LD     = CNTW'(GAP - 1);
    localparam logic [PENDW-1:0] PEND_MAX   = {PENDW{1'b1}};

    if (STRETCH < 1 || STRETCH > MAX_STRETCH || GAP < 1 || GAP > MAX_STRETCH) begin : g_param_err
        $error("mpmc12_ack_chan: STRETCH and GAP must be in 1..%0d", MAX_STRETCH);
    end

    ack_state_t       state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [PENDW-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             ack_q, ack_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             ovf_set;

    logic cnt_zero_c;
    logic launch_c;
    logic take_pend_c;
    logic queue_evt_c;

    assign cnt_zero_c  = (cnt_q == '0);
    // End of the low gap with work waiting: start the next stretch.
    assign launch_c    = (state_q == LOW) && cnt_zero_c && ((pend_q != '0) || evt);
    assign take_pend_c = launch_c && (pend_q != '0);
    // An event that launches from an empty queue is used directly instead of being counted.
    assign queue_evt_c = evt && (state_q != IDLE) && !(launch_c && (pend_q == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            ack_q   <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            ack_q   <= ack_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (evt) begin
                    state_d = HIGH;
                    cnt_d   = STRETCH_LD;
                end
            end
            HIGH: begin
                if (cnt_zero_c) begin
                    state_d = LOW;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            LOW: begin
                if (cnt_zero_c) begin
                    if (launch_c) begin
                        state_d = HIGH;
                        cnt_d   = STRETCH_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        if (take_pend_c && !evt) begin
            pend_d = pend_q - PENDW'(1);
        end else if (queue_evt_c && !take_pend_c) begin
            if (pend_q == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + PENDW'(1);
            end
        end
        ovf_d   = ovf_set | (ovf_q & ~ovf_clr);
        ack_d   = (state_d == HIGH);
        pulse_d = (state_d == HIGH) && (state_q != HIGH);
        busy_d  = (state_d != IDLE) || (pend_d != '0);
    end

    assign ack_stretch = ack_q;
    assign ack_pulse   = pulse_q;
    assign pend_cnt    = pend_q;
    assign ovf         = ovf_q;
    assign busy        = busy_q;

endmodule

// File: rtl/mpmc12_rd_ack_gen.sv
// Multi-channel read-ack generator: routes each controller read-ready to its
// destination port channel and collects the per-port stretched acks.
module mpmc12_rd_ack_gen
    import mpmc12_pkg::*;
#(
    parameter  int unsigned NPORT   = 8,
    parameter  int unsigned STRETCH = 4,
    parameter  int unsigned GAP     = 2,
    parameter  int unsigned PENDW   = 3,
    localparam int unsigned PORTW   = $clog2(NPORT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic [PORTW-1:0]       fifo_port,
    input  logic [NPORT-1:0]       port_en,
    input  logic [NPORT-1:0]       ovf_clr,
    output logic [NPORT-1:0]       ack_stretch,
    output logic [NPORT-1:0]       ack_pulse,
    output logic [NPORT*PENDW-1:0] pend_cnt,
    output logic [NPORT-1:0]       ovf,
    output logic                   busy
);

    if (NPORT < 2 || NPORT > MAX_NPORT) begin : g_param_err
        $error("mpmc12_rd_ack_gen: NPORT must be in 2..%0d", MAX_NPORT);
    end

    logic [NPORT-1:0] evt_c;
    logic [NPORT-1:0] chan_busy;

    // Out-of-range or disabled destinations produce no event at all.
    always_comb begin
        evt_c = '0;
        if (rdy && (32'(fifo_port) < NPORT)) begin
            if (port_en[fifo_port]) begin
                evt_c[fifo_port] = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NPORT; i++) begin : g_chan
        mpmc12_ack_chan #(
            .STRETCH (STRETCH),
            .GAP     (GAP),
            .PENDW   (PENDW)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .evt         (evt_c[i]),
            .ovf_clr     (ovf_clr[i]),
            .ack_stretch (ack_stretch[i]),
            .ack_pulse   (ack_pulse[i]),
            .pend_cnt    (pend_cnt[i*PENDW +: PENDW]),
            .ovf         (ovf[i]),
            .busy        (chan_busy[i])
        );
    end

    assign busy = |chan_busy;

endmodule

// File: tb/tb_mpmc12_rd_ack_gen.sv
// Scoreboard bench for mpmc12_rd_ack_gen: expected ack pulses are queued with their
// cycle, a monitor pops them as pulses appear; level checks are made at fixed cycles.
module tb_mpmc12_rd_ack_gen;

    localparam int NP    = 9;
    localparam int PW    = 2;
    localparam int PORTW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic [PORTW-1:0]  fifo_port;
    logic [NP-1:0]     port_en;
    logic [NP-1:0]     ovf_clr;
    logic [NP-1:0]     ack_stretch;
    logic [NP-1:0]     ack_pulse;
    logic [NP*PW-1:0]  pend_cnt;
    logic [NP-1:0]     ovf;
    logic              busy;

    mpmc12_rd_ack_gen #(
        .NPORT   (NP),
        .STRETCH (4),
        .GAP     (2),
        .PENDW   (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .fifo_port   (fifo_port),
        .port_en     (port_en),
        .ovf_clr     (ovf_clr),
        .ack_stretch (ack_stretch),
        .ack_pulse   (ack_pulse),
        .pend_cnt    (pend_cnt),
        .ovf         (ovf),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int t0    = 0;

    typedef struct {
        int port;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, req, cyc - t0);
        end
    endtask

    function automatic logic [PW-1:0] pend_of(input int p);
        return pend_cnt[p*PW +: PW];
    endfunction

    task automatic push(input int p, input int c);
        exp_t e;
        e.port = p;
        e.cyc  = t0 + c;
        exp_q.push_back(e);
    endtask

    // Advance to the negedge of relative cycle c.
    task automatic at(input int c);
        while (cyc < t0 + c) @(negedge clk);
    endtask

    task automatic ev(input int c, input int p);
        at(c);
        rdy       = 1'b1;
        fifo_port = PORTW'(p);
    endtask

    task automatic start_test();
        @(negedge clk);
        t0 = cyc;
    endtask

    // Pulse monitor: every observed ack_pulse must match the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        for (int p = 0; p < NP; p++) begin
            if (ack_pulse[p] === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL pulse: unexpected pulse on port %0d at abs cycle %0d", p, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.port != p || e.cyc != cyc) begin
                        fails++;
                        $display("FAIL pulse: got port %0d @%0d, expected port %0d @%0d",
                                 p, cyc, e.port, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        rdy       = 1'b0;
        fifo_port = '0;
        port_en   = '1;
        ovf_clr   = '0;
        repeat (3) @(negedge clk);
        chk("rst_stretch", 32'(ack_stretch), 32'h0);
        chk("rst_pulse",   32'(ack_pulse),   32'h0);
        chk("rst_pend",    32'(pend_cnt),    32'h0);
        chk("rst_ovf",     32'(ovf),         32'h0);
        chk("rst_busy",    32'(busy),        32'h0);
        rst = 1'b0;

        // Single event, port 3
        start_test();
        push(3, 11);
        ev(10, 3);
        at(11); rdy = 1'b0;
        chk("A_stretch11", 32'(ack_stretch[3]), 32'd1);
        at(12); chk("A_pulse12", 32'(ack_pulse[3]), 32'd0);
        at(14); chk("A_stretch14", 32'(ack_stretch[3]), 32'd1);
        at(15); chk("A_stretch15", 32'(ack_stretch[3]), 32'd0);
        at(16); chk("A_busy16", 32'(busy), 32'd1);
        at(17); chk("A_busy17", 32'(busy), 32'd0);

        // Back-to-back events, port 2
        start_test();
        push(2, 11);
        push(2, 17);
        ev(10, 2);
        ev(11, 2);
        at(12); rdy = 1'b0;
        chk("B_pend12", 32'(pend_of(2)), 32'd1);
        at(16);
        chk("B_pend16",    32'(pend_of(2)),    32'd1);
        chk("B_stretch16", 32'(ack_stretch[2]), 32'd0);
        at(17);
        chk("B_pend17",    32'(pend_of(2)),    32'd0);
        chk("B_stretch17", 32'(ack_stretch[2]), 32'd1);
        at(20); chk("B_stretch20", 32'(ack_stretch[2]), 32'd1);
        at(21); chk("B_stretch21", 32'(ack_stretch[2]), 32'd0);

        // Saturation and overflow, port 0
        start_test();
        push(0, 11);
        push(0, 17);
        push(0, 23);
        push(0, 29);
        ev(10, 0);
        ev(11, 0);
        ev(12, 0);
        ev(13, 0);
        at(14);
        chk("C_pend14", 32'(pend_of(0)), 32'd3);
        chk("C_ovf14",  32'(ovf[0]),     32'd0);
        ev(14, 0);
        at(15); rdy = 1'b0;
        chk("C_ovf15",  32'(ovf[0]),     32'd1);
        chk("C_pend15", 32'(pend_of(0)), 32'd3);
        at(28); chk("C_pend28", 32'(pend_of(0)), 32'd1);
        at(29);
        chk("C_pend29", 32'(pend_of(0)), 32'd0);
        chk("C_ovf29",  32'(ovf[0]),     32'd1);
        at(30); ovf_clr[0] = 1'b1;
        chk("C_ovf30", 32'(ovf[0]), 32'd1);
        at(31); ovf_clr[0] = 1'b0;
        chk("C_ovf31", 32'(ovf[0]), 32'd0);
        at(35); chk("C_busy35", 32'(busy), 32'd0);

        // Ignored events: out-of-range port and disabled port
        start_test();
        ev(10, 9);
        ev(11, 15);
        at(12); port_en[5] = 1'b0; rdy = 1'b1; fifo_port = PORTW'(5);
        at(13); rdy = 1'b0; port_en = '1;
        chk("D_stretch13", 32'(ack_stretch), 32'h0);
        chk("D_pend13",    32'(pend_cnt),    32'h0);
        chk("D_ovf13",     32'(ovf),         32'h0);
        chk("D_busy13",    32'(busy),        32'h0);
        at(15);
        chk("D_stretch15", 32'(ack_stretch), 32'h0);
        chk("D_busy15",    32'(busy),        32'h0);

        // Independent channels, ports 1 and 6
        start_test();
        push(1, 11);
        push(6, 12);
        ev(10, 1);
        ev(11, 6);
        chk("E_stretch11", 32'(ack_stretch), 32'h002);
        at(12); rdy = 1'b0;
        chk("E_stretch12", 32'(ack_stretch), 32'h042);
        at(14); chk("E_stretch14", 32'(ack_stretch), 32'h042);
        at(15); chk("E_stretch15", 32'(ack_stretch), 32'h040);
        at(16); chk("E_stretch16", 32'(ack_stretch), 32'h000);

        // port_en dropped mid-operation, port 7
        start_test();
        push(7, 11);
        push(7, 17);
        ev(10, 7);
        ev(11, 7);
        at(12); port_en[7] = 1'b0;
        chk("G_pend12", 32'(pend_of(7)), 32'd1);
        at(13); rdy = 1'b0; port_en = '1;
        chk("G_pend13", 32'(pend_of(7)), 32'd1);
        at(17);
        chk("G_stretch17", 32'(ack_stretch[7]), 32'd1);
        chk("G_pend17",    32'(pend_of(7)),    32'd0);
        at(21); chk("G_stretch21", 32'(ack_stretch[7]), 32'd0);
        at(23); chk("G_busy23", 32'(busy), 32'd0);

        // Reset mid-stretch discards the active ack and queued ack, port 4
        start_test();
        push(4, 11);
        push(4, 16);
        ev(10, 4);
        ev(11, 4);
        at(12); rdy = 1'b0; rst = 1'b1;
        chk("F_stretch12", 32'(ack_stretch[4]), 32'd1);
        chk("F_pend12",    32'(pend_of(4)),    32'd1);
        at(13); rst = 1'b0;
        chk("F_stretch13", 32'(ack_stretch), 32'h0);
        chk("F_pulse13",   32'(ack_pulse),   32'h0);
        chk("F_pend13",    32'(pend_cnt),    32'h0);
        chk("F_ovf13",     32'(ovf),         32'h0);
        chk("F_busy13",    32'(busy),        32'h0);
        ev(15, 4);
        at(16); rdy = 1'b0;
        chk("F_stretch16", 32'(ack_stretch[4]), 32'd1);
        at(19); chk("F_stretch19", 32'(ack_stretch[4]), 32'd1);
        at(20); chk("F_stretch20", 32'(ack_stretch[4]), 32'd0);
        at(25); chk("F_busy25", 32'(busy), 32'd0);

        at(30);
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
